// File: rtl/imem_load_ctrl_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_load_ctrl.
// The master side is the byte source / session host; the slave side is the controller.
interface imem_load_ctrl_if;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  modport master (
    output load_start,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata,
    input  cpu_hold,
    input  load_done,
    input  load_err
  );

  modport slave (
    input  load_start,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata,
    output cpu_hold,
    output load_done,
    output load_err
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader: header byte N, then 4*N little-endian data bytes written as words.
// Define IMEM_LOAD_CHECKSUM_EN to expect a trailing XOR checksum byte after the last word.
module imem_load_ctrl #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned START_ADDR = 0
) (
  input logic             clock,
  input logic             reset,
  imem_load_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StBytes,
    StWrite,
    StCsum,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     word_q, word_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            ready_q, ready_d;
  logic            hold_q, hold_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic        xfer;
  logic [31:0] addr_sum;
  logic [31:0] addr_wrap;

  assign xfer = bus.byte_valid & ready_q;

  // START_ADDR and word_idx are both below DEPTH, so one subtraction wraps the sum.
  always_comb begin
    addr_sum  = START_ADDR + 32'(word_idx_q);
    addr_wrap = (addr_sum >= DEPTH) ? (addr_sum - DEPTH) : addr_sum;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.load_start) begin
          state_d    = StHdr;
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_idx_d = 2'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end

      StHdr: begin
        if (xfer) begin
          if ({24'd0, bus.byte_data} > DEPTH) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            count_d = (bus.byte_data == 8'd0) ? CntW'(DEPTH) : CntW'(bus.byte_data);
            state_d = StBytes;
          end
        end
      end

      StBytes: begin
        if (xfer) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_d     = csum_q ^ bus.byte_data;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = bus.byte_data;
            2'd1: word_d[15:8]  = bus.byte_data;
            2'd2: word_d[23:16] = bus.byte_data;
            default: begin
              wdata_d = {bus.byte_data, word_q};
              waddr_d = addr_wrap;
              state_d = StWrite;
            end
          endcase
        end
      end

      StWrite: begin
        if (word_idx_q == count_q - CntW'(1)) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else begin
          word_idx_d = word_idx_q + CntW'(1);
          state_d    = StBytes;
        end
      end

`ifdef IMEM_LOAD_CHECKSUM_EN
      StCsum: begin
        if (xfer) begin
          if (bus.byte_data != csum_q) begin
            err_d = 1'b1;
          end
          state_d = StDone;
        end
      end
`endif

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the state being entered, so they line up with it.
    ready_d = (state_d == StHdr) || (state_d == StBytes) || (state_d == StCsum);
    hold_d  = (state_d == StHdr) || (state_d == StBytes) || (state_d == StWrite) ||
              (state_d == StCsum);
    we_d    = (state_d == StWrite);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      waddr_q    <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: two instances (START_ADDR 0 and 30) share one byte stream.
// Honours IMEM_LOAD_CHECKSUM_EN by sending the expected trailer byte at the end of each session.
module tb_imem_load_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int done0   = 0;
  logic [7:0]  tb_csum = 8'd0;
  logic [31:0] q0_addr[$];
  logic [31:0] q0_data[$];
  logic [31:0] q1_addr[$];
  logic [31:0] q1_data[$];

  always #5 clock = ~clock;

  imem_load_ctrl_if if0 ();
  imem_load_ctrl_if if1 ();

  assign if0.load_start = load_start;
  assign if0.byte_valid = byte_valid;
  assign if0.byte_data  = byte_data;
  assign if1.load_start = load_start;
  assign if1.byte_valid = byte_valid;
  assign if1.byte_data  = byte_data;

  imem_load_ctrl #(.DEPTH(32), .START_ADDR(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (if0.slave)
  );

  imem_load_ctrl #(.DEPTH(32), .START_ADDR(30)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1.slave)
  );

  always @(negedge clock) begin
    if (if0.imem_we === 1'b1) begin
      q0_addr.push_back(if0.imem_waddr);
      q0_data.push_back(if0.imem_wdata);
    end
    if (if1.imem_we === 1'b1) begin
      q1_addr.push_back(if1.imem_waddr);
      q1_data.push_back(if1.imem_wdata);
    end
    if (if0.load_done === 1'b1) done0++;
  end

  task automatic clear_log();
    q0_addr.delete();
    q0_data.delete();
    q1_addr.delete();
    q1_data.delete();
    tb_csum = 8'd0;
  endtask

  task automatic start_session();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles; returns on the negedge after it was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    acc        = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = if0.byte_ready;
      @(negedge clock);
    end
    byte_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte %h not accepted, required acceptance within 40 cycles",
               b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      tb_csum = tb_csum ^ b;
      send_byte(b, gap);
    end
  endtask

  task automatic end_session();
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_byte(tb_csum, 0);
`else
    @(negedge clock);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({if0.byte_ready, if0.imem_we, if0.cpu_hold, if0.load_done, if0.load_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {if0.byte_ready, if0.imem_we, if0.cpu_hold, if0.load_done, if0.load_err});
    end
    n_tests++;
    if ({if0.imem_waddr, if0.imem_wdata} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h/%h required 0/0", if0.imem_waddr, if0.imem_wdata);
    end
    reset = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({if0.byte_ready, if0.cpu_hold} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_ignores_bytes: ready/hold got %b required 00",
               {if0.byte_ready, if0.cpu_hold});
    end
    byte_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    clear_log();
    start_session();
    n_tests++;
    if ({if0.cpu_hold, if0.byte_ready, if0.load_err} !== 3'b110) begin
      n_fail++;
      $display("FAIL basic_hdr_state: hold/ready/err got %b required 110",
               {if0.cpu_hold, if0.byte_ready, if0.load_err});
    end
    send_byte(8'h02, 0);
    send_word(32'h00B30013, 0);
    n_tests++;
    if ({if0.imem_we, if0.imem_waddr, if0.imem_wdata} !== {1'b1, 32'd0, 32'h00B30013}) begin
      n_fail++;
      $display("FAIL basic_word0: we/addr/data got %b/%h/%h required 1/0/00b30013",
               if0.imem_we, if0.imem_waddr, if0.imem_wdata);
    end
    send_word(32'h403100B3, 0);
    n_tests++;
    if ({if0.imem_we, if0.imem_waddr, if0.imem_wdata} !== {1'b1, 32'd1, 32'h403100B3}) begin
      n_fail++;
      $display("FAIL basic_word1: we/addr/data got %b/%h/%h required 1/1/403100b3",
               if0.imem_we, if0.imem_waddr, if0.imem_wdata);
    end
    end_session();
    n_tests++;
    if ({if0.load_done, if0.cpu_hold, if0.imem_we, if0.load_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL basic_done: done/hold/we/err got %b required 1000",
               {if0.load_done, if0.cpu_hold, if0.imem_we, if0.load_err});
    end
    @(negedge clock);
    n_tests++;
    if ({if0.load_done, if0.byte_ready, if0.imem_wdata} !== {2'b00, 32'h403100B3}) begin
      n_fail++;
      $display("FAIL basic_idle_hold: done/ready/data got %b/%b/%h required 0/0/403100b3",
               if0.load_done, if0.byte_ready, if0.imem_wdata);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] words [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    logic [31:0] exp1 [4]  = '{32'd30, 32'd31, 32'd0, 32'd1};
    clear_log();
    start_session();
    n_tests++;
    if (if0.cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_hold_hdr: got %b required 1", if0.cpu_hold);
    end
    send_byte(8'd4, 0);
    for (int k = 0; k < 4; k++) begin
      send_word(words[k], 0);
      n_tests++;
      if (if1.cpu_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_hold_word%0d: got %b required 1", k, if1.cpu_hold);
      end
    end
    end_session();
    n_tests++;
    if ({if1.load_done, if1.cpu_hold} !== 2'b10) begin
      n_fail++;
      $display("FAIL wrap_done: done/hold got %b required 10", {if1.load_done, if1.cpu_hold});
    end
    @(negedge clock);
    n_tests++;
    if (q1_addr.size() != 4 || q0_addr.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d/%0d writes required 4/4", q1_addr.size(), q0_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if ({q1_addr[k], q1_data[k], q0_addr[k]} !== {exp1[k], words[k], 32'(k)}) begin
          n_fail++;
          $display("FAIL wrap_word%0d: addr1/data/addr0 got %0d/%h/%0d required %0d/%h/%0d", k,
                   q1_addr[k], q1_data[k], q0_addr[k], exp1[k], words[k], k);
        end
      end
    end
  endtask

  task automatic test_full_depth();
    clear_log();
    start_session();
    send_byte(8'd0, 0);
    for (int k = 0; k < 32; k++) send_word(32'hA5000000 | 32'(k), 0);
    end_session();
    @(negedge clock);
    n_tests++;
    if (q0_addr.size() != 32 || q1_addr.size() != 32) begin
      n_fail++;
      $display("FAIL depth_count: got %0d/%0d writes required 32/32",
               q0_addr.size(), q1_addr.size());
    end else begin
      n_tests++;
      if ({q0_addr[31], q0_data[31], q1_addr[31]} !== {32'd31, 32'hA500001F, 32'd29}) begin
        n_fail++;
        $display("FAIL depth_last: addr0/data/addr1 got %0d/%h/%0d required 31/a500001f/29",
                 q0_addr[31], q0_data[31], q1_addr[31]);
      end
    end
  endtask

  task automatic test_hdr_err();
    int d;
    clear_log();
    d = done0;
    start_session();
    send_byte(8'd40, 0);
    n_tests++;
    if ({if0.load_err, if0.load_done, if0.cpu_hold, if0.byte_ready} !== 4'b1100) begin
      n_fail++;
      $display("FAIL hdr_err_done: err/done/hold/ready got %b required 1100",
               {if0.load_err, if0.load_done, if0.cpu_hold, if0.byte_ready});
    end
    repeat (3) @(negedge clock);
    n_tests++;
    if (if0.load_err !== 1'b1 || q0_addr.size() != 0 || done0 != d + 1) begin
      n_fail++;
      $display("FAIL hdr_err_sticky: err/writes/dones got %b/%0d/%0d required 1/0/1",
               if0.load_err, q0_addr.size(), done0 - d);
    end
    start_session();
    n_tests++;
    if (if0.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hdr_err_clear: got %b required 0", if0.load_err);
    end
    send_byte(8'd1, 0);
    send_word(32'h0BADF00D, 0);
    end_session();
    @(negedge clock);
    n_tests++;
    if (q0_addr.size() != 1 || if0.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hdr_err_recover: writes/err got %0d/%b required 1/0",
               q0_addr.size(), if0.load_err);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'hB3, 8'h00, 8'hB3, 8'h00, 8'h31, 8'h40};
    int         gaps  [8] = '{1, 2, 1, 3, 1, 1, 2, 1};
    int d;
    clear_log();
    d = done0;
    start_session();
    send_byte(8'h02, 1);
    for (int i = 0; i < 8; i++) begin
      tb_csum = tb_csum ^ bytes[i];
      send_byte(bytes[i], gaps[i]);
      if (i == 3) begin
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
      end
    end
    end_session();
    @(negedge clock);
    n_tests++;
    if (q0_addr.size() != 2 || done0 != d + 1 || if0.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_count: writes/dones/err got %0d/%0d/%b required 2/1/0",
               q0_addr.size(), done0 - d, if0.load_err);
    end else begin
      n_tests++;
      if ({q0_addr[0], q0_data[0], q0_addr[1], q0_data[1]} !==
          {32'd0, 32'h00B30013, 32'd1, 32'h403100B3}) begin
        n_fail++;
        $display("FAIL gaps_words: got %0d:%h %0d:%h required 0:00b30013 1:403100b3",
                 q0_addr[0], q0_data[0], q0_addr[1], q0_data[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d;
    clear_log();
    d = done0;
    start_session();
    send_byte(8'd1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({if0.byte_ready, if0.imem_we, if0.cpu_hold, if0.load_done, if0.load_err,
         if0.imem_waddr, if0.imem_wdata} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: ready/we/hold/done/err got %b, addr/data %h/%h, required 0",
               {if0.byte_ready, if0.imem_we, if0.cpu_hold, if0.load_done, if0.load_err},
               if0.imem_waddr, if0.imem_wdata);
    end
    reset = 1'b0;
    repeat (4) @(negedge clock);
    n_tests++;
    if (q0_addr.size() != 0 || done0 != d) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: writes/dones got %0d/%0d required 0/0",
               q0_addr.size(), done0 - d);
    end
    tb_csum = 8'd0;
    start_session();
    send_byte(8'd1, 0);
    send_word(32'h44332211, 0);
    end_session();
    @(negedge clock);
    n_tests++;
    if (q0_addr.size() != 1 || done0 != d + 1) begin
      n_fail++;
      $display("FAIL reset_mid_resume: writes/dones got %0d/%0d required 1/1",
               q0_addr.size(), done0 - d);
    end else begin
      n_tests++;
      if ({q0_addr[0], q0_data[0]} !== {32'd0, 32'h44332211}) begin
        n_fail++;
        $display("FAIL reset_mid_word: got %0d:%h required 0:44332211", q0_addr[0], q0_data[0]);
      end
    end
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    start_session();
    send_byte(8'd1, 0);
    send_word(32'h04030201, 0);
    send_byte(8'h04, 0);
    n_tests++;
    if ({if0.load_done, if0.load_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL csum_good: done/err got %b required 10", {if0.load_done, if0.load_err});
    end
    @(negedge clock);
    start_session();
    send_byte(8'd1, 0);
    send_word(32'h04030201, 0);
    send_byte(8'h05, 0);
    n_tests++;
    if ({if0.load_done, if0.load_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL csum_bad: done/err got %b required 11", {if0.load_done, if0.load_err});
    end
    @(negedge clock);
    n_tests++;
    if (q0_data.size() != 2 || q0_data[q0_data.size() - 1] !== 32'h04030201) begin
      n_fail++;
      $display("FAIL csum_written: writes %0d, last %h required 2, 04030201",
               q0_data.size(), (q0_data.size() > 0) ? q0_data[q0_data.size() - 1] : 32'hx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full_depth();
    test_hdr_err();
    test_gaps();
    test_reset_mid();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end
endmodule
